// File: rtl/coincidence_readout.sv
// coincidence_readout: snapshots pair counts on Start and streams an A5/LEN/DATA byte frame.
// Define READOUT_CHKSUM_EN to append an XOR checksum byte (LEN ^ data) after the data.
module coincidence_readout #(
    parameter  int NCHAN  = 6,
    parameter  int NBITS  = 4,
    localparam int NPAIRS = NCHAN * (NCHAN - 1) / 2,
    localparam int NBYTES = (NBITS + 7) / 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NBITS-1:0] i_counts [NPAIRS-1:0],
    input  logic             i_start,
    output logic [7:0]       o_tx_data,
    output logic             o_tx_valid,
    output logic             o_tx_last,
    input  logic             i_tx_ready,
    output logic             o_busy,
    output logic             o_overrun
);
    localparam int PW = $clog2(NPAIRS + 1);
    localparam int BW = $clog2(NBYTES + 1);
    localparam logic [7:0]    LEN_BYTE = 8'(NPAIRS * NBYTES);
    localparam logic [PW-1:0] P_LAST   = PW'(NPAIRS - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(NBYTES - 1);

    typedef enum logic [2:0] {IDLE, HDR, LEN, DATA, CHK} state_t;

    generate
        if (NPAIRS * NBYTES > 255) begin : g_bad_size
            $error("coincidence_readout: NPAIRS*NBYTES must not exceed 255");
        end
    endgenerate

    state_t              r_state, w_next;
    logic [NBITS-1:0]    r_snap [NPAIRS-1:0];
    logic [PW-1:0]       r_pidx;
    logic [BW-1:0]       r_bidx;
    logic                r_overrun;
    logic [NBYTES*8-1:0] w_word;
    logic [7:0]          w_byte;
    logic [7:0]          w_chk;
    logic                w_hs;
    logic                w_end;
    logic                w_last;

    assign w_word = (NBYTES*8)'(r_snap[r_pidx]);
    assign w_byte = w_word[r_bidx*8 +: 8];
    assign w_hs   = o_tx_valid && i_tx_ready;
    assign w_end  = (r_pidx == P_LAST) && (r_bidx == B_LAST);

`ifdef READOUT_CHKSUM_EN
    localparam state_t DATA_NEXT = CHK;
    logic [7:0] r_chk;
    assign w_chk  = r_chk;
    assign w_last = r_state == CHK;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_chk <= 8'h00;
        else if (w_hs && r_state == LEN)
            r_chk <= LEN_BYTE;
        else if (w_hs && r_state == DATA)
            r_chk <= r_chk ^ w_byte;
    end
`else
    localparam state_t DATA_NEXT = IDLE;
    assign w_chk  = 8'h00;
    assign w_last = (r_state == DATA) && w_end;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_pidx    <= '0;
            r_bidx    <= '0;
            r_overrun <= 1'b0;
            for (int i = 0; i < NPAIRS; i++) r_snap[i] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && i_start) begin
                r_snap    <= i_counts;
                r_overrun <= 1'b0;
                r_pidx    <= '0;
                r_bidx    <= '0;
            end else if (i_start) begin
                r_overrun <= 1'b1;
            end
            if (w_hs && r_state == DATA) begin
                r_bidx <= (r_bidx == B_LAST) ? '0 : r_bidx + 1'b1;
                if (r_bidx == B_LAST) r_pidx <= (r_pidx == P_LAST) ? '0 : r_pidx + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = i_start ? HDR : IDLE;
            HDR:     w_next = w_hs ? LEN : HDR;
            LEN:     w_next = w_hs ? DATA : LEN;
            DATA:    w_next = (w_hs && w_end) ? DATA_NEXT : DATA;
            CHK:     w_next = w_hs ? IDLE : CHK;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        o_tx_valid = r_state != IDLE;
        o_busy     = r_state != IDLE;
        o_overrun  = r_overrun;
        o_tx_last  = w_last;
        o_tx_data  = (r_state == HDR)  ? 8'hA5 :
                     (r_state == LEN)  ? LEN_BYTE :
                     (r_state == DATA) ? w_byte :
                     (r_state == CHK)  ? w_chk : 8'h00;
    end
endmodule
